// File: rtl/cool_heat_system.sv
// rtl/cool_heat_system.sv - cool/heat actuator: soft-ramped power, break-before-make mode, PWM fan drive
module cool_heat_system #(
  parameter int CNT_W = 8,
  parameter int PWR_W = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [7:0]       speed,
  input  logic [7:0]       chs_conf,
  output logic [PWR_W-1:0] chs_power,
  output logic             chs_mode,
  output logic             pwm_data
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [PWR_W-1:0] power_q, power_d;
  logic             mode_q, mode_d;
  logic             pwm_q, pwm_d;

  logic             tick;
  logic [PWR_W-1:0] target;
  logic             req;

  assign tick   = (cnt_q == {CNT_W{1'b1}});
  assign target = PWR_W'(chs_conf[3:0]);
  assign req    = chs_conf[4];

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    // Duty is only reloaded at the period boundary so a mid-period speed change cannot glitch the output.
    duty_d = tick ? CNT_W'(speed) : duty_q;
    pwm_d  = (power_q != '0) && (cnt_q < duty_q);
  end

  always_comb begin
    power_d = power_q;
    mode_d  = mode_q;
    if (tick) begin
      if (req != mode_q) begin
        // Break-before-make: drain power fully before flipping the mode.
        if (power_q != '0) begin
          power_d = power_q - 1'b1;
        end else begin
          mode_d = req;
        end
      end else if (power_q < target) begin
        power_d = power_q + 1'b1;
      end else if (power_q > target) begin
        power_d = power_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      power_q <= '0;
      mode_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      power_q <= power_d;
      mode_q  <= mode_d;
      pwm_q   <= pwm_d;
    end
  end

  assign chs_power = power_q;
  assign chs_mode  = mode_q;
  assign pwm_data  = pwm_q;

endmodule

// File: tb/tb_cool_heat_system.sv
// tb/tb_cool_heat_system.sv - directed self-checking bench for cool_heat_system
module tb_cool_heat_system;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] speed;
  logic [7:0] chs_conf;
  logic [3:0] chs_power;
  logic       chs_mode;
  logic       pwm_data;

  int passed = 0;
  int total  = 0;

  cool_heat_system dut (
    .clk       (clk),
    .arst      (arst),
    .speed     (speed),
    .chs_conf  (chs_conf),
    .chs_power (chs_power),
    .chs_mode  (chs_mode),
    .pwm_data  (pwm_data)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_pwm(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pwm_data === 1'b1) highs++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    int h1, h2;

    arst = 1'b1; speed = 8'h00; chs_conf = 8'h00;
    clk_n(2);
    chk("rst_power", 32'(chs_power), 0);
    chk("rst_mode",  32'(chs_mode),  0);
    chk("rst_pwm",   32'(pwm_data),  0);

    arst = 1'b0;
    count_pwm(600, h1);
    chk("zero_speed_pwm_highs", h1, 0);
    chk("zero_conf_power", 32'(chs_power), 0);

    // Startup ramp from a fresh reset.
    arst = 1'b1;
    clk_n(1);
    arst = 1'b0; speed = 8'h80; chs_conf = 8'h1F;
    clk_n(255);
    chk("pre_tick1_mode", 32'(chs_mode), 0);
    clk_n(1);
    chk("tick1_mode",  32'(chs_mode),  1);
    chk("tick1_power", 32'(chs_power), 0);
    for (int t = 1; t <= 15; t++) begin
      clk_n(256);
      chk("ramp_up_power", 32'(chs_power), t);
    end
    clk_n(256);
    chk("hold15_power", 32'(chs_power), 15);
    chk("hold15_mode",  32'(chs_mode),  1);

    // Duty 0x80; speed changed at cnt=100 must not alter this period.
    count_pwm(100, h1);
    speed = 8'h40;
    count_pwm(28, h2);
    chk("duty80_first_half_highs", h1 + h2, 128);
    count_pwm(128, h1);
    chk("duty80_second_half_highs", h1, 0);
    count_pwm(64, h1);
    chk("duty40_first64_highs", h1, 64);
    count_pwm(192, h1);
    chk("duty40_rest_highs", h1, 0);

    // Mode change cool -> heat.
    chs_conf = 8'h0F;
    for (int k = 1; k <= 15; k++) begin
      clk_n(256);
      chk("drain_power", 32'(chs_power), 15 - k);
      chk("drain_mode",  32'(chs_mode),  1);
    end
    count_pwm(256, h1);
    chk("zero_power_pwm_highs", h1, 0);
    chk("flip_mode",  32'(chs_mode),  0);
    chk("flip_power", 32'(chs_power), 0);
    for (int k = 1; k <= 15; k++) begin
      clk_n(256);
      chk("heat_ramp_power", 32'(chs_power), k);
    end
    chk("heat_ramp_mode", 32'(chs_mode), 0);

    // A conf change between ticks is ignored.
    clk_n(50);
    chs_conf = 8'h10;
    clk_n(10);
    chs_conf = 8'h0F;
    clk_n(196);
    chk("glitch_power", 32'(chs_power), 15);
    chk("glitch_mode",  32'(chs_mode),  0);

    // Back to cooling with reserved bits set.
    chs_conf = 8'hFF;
    for (int k = 1; k <= 15; k++) begin
      clk_n(256);
      chk("ff_drain_power", 32'(chs_power), 15 - k);
    end
    clk_n(256);
    chk("ff_flip_mode",  32'(chs_mode),  1);
    chk("ff_flip_power", 32'(chs_power), 0);
    for (int k = 1; k <= 15; k++) begin
      clk_n(256);
      chk("ff_ramp_power", 32'(chs_power), k);
    end

    // Down-ramp to 5, reserved bits set.
    chs_conf = 8'hF5;
    for (int k = 1; k <= 10; k++) begin
      clk_n(256);
      chk("down_power", 32'(chs_power), 15 - k);
      chk("down_mode",  32'(chs_mode),  1);
    end
    clk_n(256);
    chk("down_hold_power", 32'(chs_power), 5);

    // Request reverts during a ramp-down: no flip, ramp toward new target.
    chs_conf = 8'h05;
    clk_n(256);
    chk("revert_drain_power", 32'(chs_power), 4);
    chs_conf = 8'h18;
    clk_n(256);
    chk("revert_up_power", 32'(chs_power), 5);
    chk("revert_mode",     32'(chs_mode),  1);
    clk_n(1);
    chk("pre_reset_pwm", 32'(pwm_data), 1);

    // Reset mid-operation.
    arst = 1'b1;
    clk_n(1);
    chk("midrst_power", 32'(chs_power), 0);
    chk("midrst_mode",  32'(chs_mode),  0);
    chk("midrst_pwm",   32'(pwm_data),  0);
    arst = 1'b0; speed = 8'h80; chs_conf = 8'h1F;
    clk_n(255);
    chk("post_rst_pre_tick_mode", 32'(chs_mode), 0);
    clk_n(1);
    chk("post_rst_tick_mode", 32'(chs_mode), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
